shift_seq_unit: RTL



---
 rtl/shift_seq_pkg.sv | 29 ++
 rtl/shift_seq_step.sv | 26 ++
 rtl/shift_seq_unit.sv | 107 ++++++++++
 3 files changed

// File: rtl/shift_seq_pkg.sv
// Shared opcode and FSM state definitions for the iterative shifter.
// Rotate opcodes are legal only when SHIFT_SEQ_ROTATE_EN is defined.
package shift_seq_pkg;

    localparam int AMT_W = 5;

    typedef enum logic [2:0] {
        OP_SLL = 3'd0,
        OP_SRL = 3'd1,
        OP_SRA = 3'd2,
        OP_ROL = 3'd3,
        OP_ROR = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic op_legal(input logic [2:0] op);
`ifdef SHIFT_SEQ_ROTATE_EN
        return op <= OP_ROR;
`else
        return op <= OP_SRA;
`endif
    endfunction

endpackage

// File: rtl/shift_seq_step.sv
// Combinational single-position shift/rotate of a 32-bit value.
// Rotate steps exist only when SHIFT_SEQ_ROTATE_EN is defined.
module shift_seq_step
    import shift_seq_pkg::*;
(
    input  logic [31:0] value,
    input  logic [2:0]  op,
    output logic [31:0] stepped
);

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves stepped unassigned (no latch).
        stepped = value;
        case (op)
            OP_SLL:  stepped = {value[30:0], 1'b0};
            OP_SRL:  stepped = {1'b0, value[31:1]};
            OP_SRA:  stepped = {value[31], value[31:1]};
`ifdef SHIFT_SEQ_ROTATE_EN
            OP_ROL:  stepped = {value[30:0], value[31]};
            OP_ROR:  stepped = {value[0], value[31:1]};
`endif
            default: stepped = value;
        endcase
    end

endmodule

// File: rtl/shift_seq_unit.sv
// Multi-cycle iterative shifter: one bit position per clock, registered done/result.
// Build option SHIFT_SEQ_ROTATE_EN enables the ROL/ROR opcodes.
module shift_seq_unit
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] shift_amt,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             op_err
);

    state_e             state_q, state_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               op_err_q, op_err_d;
    logic [WIDTH-1:0]   step_out;

    shift_seq_step u_step (
        .value   (acc_q),
        .op      (op_q),
        .stepped (step_out)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        op_d     = op_q;
        result_d = result_q;
        op_err_d = op_err_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d    = data_in;
                    cnt_d    = shift_amt;
                    op_d     = op;
                    op_err_d = !op_legal(op);
                    // Illegal ops and zero amounts skip SHIFT; result is the operand itself.
                    if (!op_legal(op) || shift_amt == '0) begin
                        state_d  = ST_DONE;
                        done_d   = 1'b1;
                        result_d = data_in;
                    end else begin
                        state_d = ST_SHIFT;
                        busy_d  = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                acc_d = step_out;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == AMT_W'(1)) begin
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    result_d = step_out;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are driven straight from flops so no input reaches them combinationally.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values, whatever the statement order.
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            op_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            op_q     <= op_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            op_err_q <= op_err_d;
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign op_err = op_err_q;

endmodule
